// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// rv_pkg : shared RV constants and load-format encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Load formats, encoded as the funct3 field of the load instruction
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_fmt_e;

  localparam logic c_grant_alu = 1'b0;
  localparam logic c_grant_ld  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
//------------------------------------------------------------------------------
// load_extend : byte/halfword/word extraction and sign/zero extension of load data
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_extend
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_offset, 3'b000} +: 8];
  assign w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_funct3)
      LB:      o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      LBU:     o_data = {{(XLEN-8){1'b0}}, w_byte};
      LH:      o_data = {{(XLEN-16){w_half[15]}}, w_half};
      LHU:     o_data = {{(XLEN-16){1'b0}}, w_half};
      LW:      o_data = i_rdata;
      // Unsupported encodings write zero and flag the error
      default: o_err  = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
//------------------------------------------------------------------------------
// regfile_writeback : arbitrates ALU/load results onto one register-file write port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_writeback
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [4:0]      i_ld_rd,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_offset,
  input  logic [XLEN-1:0] i_ld_rdata,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  output logic [4:0]      o_rd_waddr,
  output logic            o_rd_wvalid,
  output logic [XLEN-1:0] o_rd_wdata,
  output logic [31:0]     o_pending,
  output logic            o_ld_err
);

  logic            r_last_grant;
  logic            r_wvalid;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_ld_err;
  logic [31:0]     r_pending;

  logic            w_ld_sel;
  logic            w_tie;
  logic            w_xfer_alu;
  logic            w_xfer_ld;
  logic            w_xfer;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_fmt_err;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;
  logic [31:0]     w_pend_nxt;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_funct3 (i_ld_funct3),
    .i_offset (i_ld_offset),
    .i_rdata  (i_ld_rdata),
    .o_data   (w_ld_data),
    .o_err    (w_ld_fmt_err)
  );

  // Load wins when alone, or on a tie when the ALU was granted last
  assign w_tie       = i_alu_valid & i_ld_valid;
  assign w_ld_sel    = i_ld_valid & (~i_alu_valid | (r_last_grant == c_grant_alu));
  assign o_ld_ready  = rstn & w_ld_sel;
  assign o_alu_ready = rstn & ~w_ld_sel;

  assign w_xfer_alu = i_alu_valid & o_alu_ready;
  assign w_xfer_ld  = i_ld_valid & o_ld_ready;
  assign w_xfer     = w_xfer_alu | w_xfer_ld;
  assign w_rd       = w_xfer_ld ? i_ld_rd : i_alu_rd;
  assign w_data     = w_xfer_ld ? w_ld_data : i_alu_data;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_issue_valid) w_set[i_issue_rd] = 1'b1;
    if (w_xfer)        w_clr[w_rd]       = 1'b1;
    // Set after clear so a same-edge issue keeps the bit pending
    w_pend_nxt    = (r_pending & ~w_clr) | w_set;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_grant <= c_grant_alu;
      r_wvalid     <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_ld_err     <= 1'b0;
      r_pending    <= '0;
    end else begin
      r_wvalid  <= w_xfer & (w_rd != 5'd0);
      r_ld_err  <= w_xfer_ld & w_ld_fmt_err;
      r_pending <= w_pend_nxt;
      if (w_xfer) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
      end
      if (w_tie) r_last_grant <= w_ld_sel;
    end
  end

  assign o_rd_wvalid = r_wvalid;
  assign o_rd_waddr  = r_waddr;
  assign o_rd_wdata  = r_wdata;
  assign o_ld_err    = r_ld_err;
  assign o_pending   = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
//------------------------------------------------------------------------------
// tb_regfile_writeback : directed-vector self-checking bench for regfile_writeback
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_writeback;

  localparam int XLEN = 32;

  logic            clk;
  logic            rstn;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid, ld_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_offset;
  logic [XLEN-1:0] ld_rdata;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      rd_waddr;
  logic            rd_wvalid;
  logic [XLEN-1:0] rd_wdata;
  logic [31:0]     pending;
  logic            ld_err;

  int n_cmp = 0;
  int n_err = 0;

  regfile_writeback #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_alu_valid   (alu_valid),
    .o_alu_ready   (alu_ready),
    .i_alu_rd      (alu_rd),
    .i_alu_data    (alu_data),
    .i_ld_valid    (ld_valid),
    .o_ld_ready    (ld_ready),
    .i_ld_rd       (ld_rd),
    .i_ld_funct3   (ld_funct3),
    .i_ld_offset   (ld_offset),
    .i_ld_rdata    (ld_rdata),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .o_rd_waddr    (rd_waddr),
    .o_rd_wvalid   (rd_wvalid),
    .o_rd_wdata    (rd_wdata),
    .o_pending     (pending),
    .o_ld_err      (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    ld_valid    = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [XLEN-1:0] d);
    ld_valid  = 1'b1;
    ld_rd     = rd;
    ld_funct3 = f3;
    ld_offset = off;
    ld_rdata  = d;
  endtask

  // One load alone: readiness before the edge, formatted data after it
  task automatic load_vec(input string tag, input logic [2:0] f3, input logic [1:0] off,
                          input logic [XLEN-1:0] d, input logic [XLEN-1:0] exp);
    idle();
    drive_ld(5'd3, f3, off, d);
    #1;
    check_eq({tag, "_ready"}, ld_ready, 1);
    tick();
    check_eq({tag, "_wvalid"}, rd_wvalid, 1);
    check_eq({tag, "_wdata"}, rd_wdata, exp);
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    alu_rd = '0; alu_data = '0;
    ld_rd = '0; ld_funct3 = '0; ld_offset = '0; ld_rdata = '0;
    issue_rd = '0;

    // Reset state, with both channels requesting
    alu_valid = 1'b1;
    ld_valid  = 1'b1;
    #3;
    check_eq("rst_wvalid",  rd_wvalid, 0);
    check_eq("rst_waddr",   rd_waddr, 0);
    check_eq("rst_wdata",   rd_wdata, 0);
    check_eq("rst_lderr",   ld_err, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_alu_rdy", alu_ready, 0);
    check_eq("rst_ld_rdy",  ld_ready, 0);
    idle();
    tick();
    rstn = 1'b1;

    // Mark rd 5 pending, then ALU write to rd 5
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    tick();
    check_eq("issue5_pend", pending[5], 1);
    idle();
    drive_alu(5'd5, 32'hDEADBEEF);
    #1;
    check_eq("alu_ready", alu_ready, 1);
    check_eq("alu_ld_rdy", ld_ready, 0);
    tick();
    check_eq("alu_wvalid", rd_wvalid, 1);
    check_eq("alu_waddr",  rd_waddr, 5);
    check_eq("alu_wdata",  rd_wdata, 32'hDEADBEEF);
    check_eq("alu_pend5",  pending[5], 0);
    idle();
    tick();
    check_eq("idle_wvalid", rd_wvalid, 0);

    // Load formatting
    load_vec("lb3",  3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
    load_vec("lbu3", 3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080);
    load_vec("lb1",  3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F);
    load_vec("lh2",  3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001);
    load_vec("lhu1", 3'b101, 2'd1, 32'h8001_F234, 32'h0000_F234);
    load_vec("lw3",  3'b010, 2'd3, 32'h1234_5678, 32'h1234_5678);
    check_eq("ld_noerr", ld_err, 0);

    // Ties: first goes to load, then alternate
    idle();
    drive_alu(5'd11, 32'hA1A1_A1A1);
    drive_ld(5'd10, 3'b010, 2'd0, 32'h1D1D_1D1D);
    #1;
    check_eq("tie1_ld_rdy",  ld_ready, 1);
    check_eq("tie1_alu_rdy", alu_ready, 0);
    tick();
    check_eq("tie1_waddr", rd_waddr, 10);
    check_eq("tie2_ld_rdy",  ld_ready, 0);
    check_eq("tie2_alu_rdy", alu_ready, 1);
    tick();
    check_eq("tie2_waddr", rd_waddr, 11);
    check_eq("tie2_wdata", rd_wdata, 32'hA1A1_A1A1);
    check_eq("tie3_ld_rdy",  ld_ready, 1);
    check_eq("tie3_alu_rdy", alu_ready, 0);
    tick();
    check_eq("tie3_waddr", rd_waddr, 10);
    check_eq("tie3_wdata", rd_wdata, 32'h1D1D_1D1D);

    // Write to x0 completes but never presents
    idle();
    drive_alu(5'd0, 32'h1);
    #1;
    check_eq("x0_ready", alu_ready, 1);
    tick();
    check_eq("x0_wvalid", rd_wvalid, 0);

    // Illegal load format
    idle();
    drive_ld(5'd7, 3'b011, 2'd0, 32'hFFFF_FFFF);
    tick();
    check_eq("bad_wvalid", rd_wvalid, 1);
    check_eq("bad_waddr",  rd_waddr, 7);
    check_eq("bad_wdata",  rd_wdata, 0);
    check_eq("bad_err",    ld_err, 1);
    idle();
    tick();
    check_eq("bad_err_end", ld_err, 0);

    // Illegal format to x0 still flags
    drive_ld(5'd0, 3'b111, 2'd0, 32'h5);
    tick();
    check_eq("bad0_wvalid", rd_wvalid, 0);
    check_eq("bad0_err",    ld_err, 1);
    idle();

    // Same-edge issue and write to rd 9
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    drive_alu(5'd9, 32'h99);
    tick();
    check_eq("same9_pend", pending[9], 1);
    idle();
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    tick();
    check_eq("issue0_pend0", pending[0], 0);
    check_eq("issue0_pend9", pending[9], 1);
    idle();
    drive_alu(5'd9, 32'h9A);
    tick();
    check_eq("clr9_pend", pending[9], 0);

    // Reset mid-operation with a write presented and a bit pending
    idle();
    issue_valid = 1'b1;
    issue_rd    = 5'd13;
    drive_alu(5'd12, 32'hC0DE);
    tick();
    check_eq("pre_rst_wvalid", rd_wvalid, 1);
    check_eq("pre_rst_pend13", pending[13], 1);
    idle();
    #2;
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_wvalid",  rd_wvalid, 0);
    check_eq("mid_rst_pending", pending, 0);
    check_eq("mid_rst_wdata",   rd_wdata, 0);
    tick();
    rstn = 1'b1;
    tick();
    check_eq("post_rst_wvalid", rd_wvalid, 0);
    check_eq("post_rst_pend",   pending, 0);

    // Last-grant reset back to ALU: first tie after reset goes to load
    drive_alu(5'd1, 32'h1);
    drive_ld(5'd2, 3'b010, 2'd0, 32'h2);
    #1;
    check_eq("post_rst_tie_ld", ld_ready, 1);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data and register width.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_alu_valid input 1, o_alu_ready output 1, i_alu_rd input 5, i_alu_data input XLEN: ALU result channel.
REQ-005 SHALL have ports i_ld_valid input 1, o_ld_ready output 1, i_ld_rd input 5, i_ld_funct3 input 3, i_ld_offset input 2, i_ld_rdata input XLEN: raw load-data channel.
REQ-006 SHALL have ports i_issue_valid input 1, i_issue_rd input 5: marks a destination register as pending at issue.
REQ-007 SHALL have ports o_rd_waddr output 5, o_rd_wvalid output 1, o_rd_wdata output XLEN: register-file write port.
REQ-008 SHALL have ports o_pending output 32 (per-register pending bits) and o_ld_err output 1 (illegal load-format pulse).

Function
REQ-009 SHALL complete a channel transfer on a rising edge where valid and ready are both 1.
REQ-010 SHALL drive ready combinationally: with one channel valid, that channel's ready=1; with both valid, only the granted channel's ready=1.
REQ-011 SHALL arbitrate ties round-robin via a 1-bit last-grant register, granting the channel not granted last; last-grant updates only on tie-arbitrated transfers.
REQ-012 SHALL register the accepted write: o_rd_waddr/o_rd_wdata/o_rd_wvalid appear exactly one cycle after the transfer edge, and o_rd_wvalid is 0 in cycles following no transfer.
REQ-013 SHALL accept writes with rd=0 (handshake completes) but hold o_rd_wvalid=0 for them.
REQ-014 SHALL format load data by funct3: 000 LB sign-extend byte, 100 LBU zero-extend byte, byte = i_ld_rdata[8*offset +: 8]; 001 LH / 101 LHU sign/zero-extend halfword selected by offset[1], offset[0] ignored; 010 LW full word, offset ignored.
REQ-015 SHALL, for funct3 011/110/111, write data 0 to rd and pulse o_ld_err high for exactly the cycle o_rd_wvalid would be high (regardless of rd=0).
REQ-016 SHALL set o_pending[i_issue_rd] on the edge where i_issue_valid=1 and i_issue_rd!=0.
REQ-017 SHALL clear o_pending[rd] on the transfer edge of a write to rd.
REQ-018 SHALL, when set and clear target the same rd on the same edge, leave the bit set (new issue wins).
REQ-019 SHALL hold o_pending[0]=0 permanently.
REQ-020 SHALL impose no backpressure from the register file (write port always accepted).

Reset
REQ-021 SHALL, while rstn=0, force o_rd_wvalid=0, o_rd_waddr=0, o_rd_wdata=0, o_ld_err=0, o_pending=0, last-grant=ALU (first tie goes to load), immediately and independent of clk.
REQ-022 SHALL drop any write registered but not yet presented when rstn asserts mid-operation; no partial writes after release.
REQ-023 SHALL drive both ready outputs 0 while rstn=0.

Structure
REQ-024 SHALL take XLEN default and a load-format enum (LB, LH, LW, LBU, LHU) from shared package rv_pkg.
REQ-025 SHALL implement byte/halfword extraction and extension in combinational sub-module load_extend.
REQ-026 SHALL hold total state to: output register, last-grant bit, 32-bit pending vector (bit 0 constant).

Verification
REQ-027 ALU only: rd=5, data 0xDEADBEEF -> next cycle o_rd_wvalid=1, waddr=5, wdata=0xDEADBEEF; o_pending[5] cleared.
REQ-028 LB offset 3, rdata 0x80FF_0000 -> wdata 0xFFFFFF80; LBU same -> 0x00000080; LH offset 2, rdata 0x8001_1234 -> 0xFFFF8001.
REQ-029 Both valid three consecutive cycles after reset -> grants load, ALU, load; non-granted ready=0 each cycle.
REQ-030 Write to rd=0 with data 0x1 -> ready=1, o_rd_wvalid stays 0; funct3 011 rd=7 -> wdata 0, o_ld_err one-cycle pulse.
REQ-031 Issue rd=9 on same edge as write to rd=9 -> o_pending[9]=1 afterward; issue rd=0 -> o_pending[0]=0.
REQ-032 Assert rstn=0 mid-cycle with a registered write -> o_rd_wvalid, o_pending to 0 before next edge; no write after release.
